ss_edit_scan_ctrl: RTL

Controller that owns the four 3-bit digit values (0-7) shown on the 4-digit seven-segment display. It sequences a DISPLAY/EDIT mode FSM: in EDIT, buttons select a digit and increment it. The block drives num3..num0 into the existing seven-segment decoder and receives seg3..seg0 back. It then time-multiplexes the four decoded patterns onto one shared segment bus with digit strobes, blinking the selected digit while in EDIT.

---
 rtl/ss_edit_scan_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ss_edit_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ss_edit_scan_ctrl
//
// Owns the four 3-bit digit values (0..7) shown on a 4-digit seven-segment
// display. A two-state DISPLAY/EDIT mode machine lets the user pick a digit
// and increment it. The digit values are sent out to an external decoder.
// The decoded patterns come back and are time-multiplexed onto one shared,
// registered segment bus with active-low digit strobes. The selected digit
// blinks while in EDIT.
//
// Parameters
//   SCAN_DIV   clk cycles per digit scan slot (>= 2)
//   BLINK_DIV  clk cycles per blink half-period (>= 2)
//   BLANK      segment pattern for a blanked digit (active-low, all off)
//
// Ports
//   clk                  system clock
//   rst                  asynchronous active-high reset
//   btn_mode             pulse: toggle DISPLAY/EDIT
//   btn_next             pulse: in EDIT, select the next digit
//   btn_inc              pulse: in EDIT, increment the selected digit
//   load, load_val[11:0] pulse + value {num3,num2,num1,num0}: load all digits
//   num3..num0[2:0]      current digit values towards the decoder
//   seg3..seg0[6:0]      decoded patterns returned by the decoder
//   seg_out[6:0]         shared segment bus (registered)
//   an[3:0]              digit strobes, active-low (registered)
//   edit_mode            1 while in EDIT
//   sel[1:0]             selected digit index
// ---------------------------------------------------------------------------
module ss_edit_scan_ctrl #(
    parameter int         SCAN_DIV  = 25000,
    parameter int         BLINK_DIV = 6250000,
    parameter logic [6:0] BLANK     = 7'h7F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        load,
    input  logic [11:0] load_val,
    output logic [2:0]  num3,
    output logic [2:0]  num2,
    output logic [2:0]  num1,
    output logic [2:0]  num0,
    input  logic [6:0]  seg3,
    input  logic [6:0]  seg2,
    input  logic [6:0]  seg1,
    input  logic [6:0]  seg0,
    output logic [6:0]  seg_out,
    output logic [3:0]  an,
    output logic        edit_mode,
    output logic [1:0]  sel
);

    localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [0:0] {
        ST_DISPLAY = 1'b0,
        ST_EDIT    = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0][2:0]     r_digit;
    logic [3:0][2:0]     w_digit_nxt;
    logic [1:0]          r_sel;
    logic [1:0]          w_sel_nxt;
    logic                w_blink_restart;

    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [1:0]          r_idx;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                r_phase;

    logic [6:0]          w_seg_pick;
    logic                w_blanked;
    logic [3:0]          r_an;
    logic [6:0]          r_seg_out;

    // ---- mode FSM and digit registers --------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_DISPLAY;
            r_digit <= '0;
            r_sel   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_digit <= w_digit_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Events are resolved in strict priority order btn_mode > load >
    // btn_next > btn_inc; a lower-priority event in the same cycle is dropped.
    always_comb begin
        w_state_nxt     = r_state;
        w_digit_nxt     = r_digit;
        w_sel_nxt       = r_sel;
        w_blink_restart = 1'b0;
        case (r_state)
            ST_DISPLAY: begin
                if (btn_mode) begin
                    // Restart the blink in its visible phase so the selected
                    // digit is shown immediately on entry.
                    w_state_nxt     = ST_EDIT;
                    w_sel_nxt       = 2'd0;
                    w_blink_restart = 1'b1;
                end else if (load) begin
                    w_digit_nxt = load_val;
                end
            end
            ST_EDIT: begin
                if (btn_mode) begin
                    w_state_nxt = ST_DISPLAY;
                end else if (load) begin
                    w_digit_nxt = load_val;
                end else if (btn_next) begin
                    w_sel_nxt = r_sel + 2'd1;
                end else if (btn_inc) begin
                    w_digit_nxt[r_sel] = r_digit[r_sel] + 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_DISPLAY;
            end
        endcase
    end

    // ---- free-running scan slot counter ------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // ---- blink timebase (phase 1 = visible) --------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_blink_restart) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // ---- segment select and blanking ---------------------------------------
    always_comb begin
        w_seg_pick = seg0;
        case (r_idx)
            2'd0:    w_seg_pick = seg0;
            2'd1:    w_seg_pick = seg1;
            2'd2:    w_seg_pick = seg2;
            default: w_seg_pick = seg3;
        endcase
    end

    // The strobe stays asserted while blanked; only the pattern is replaced.
    assign w_blanked = (r_state == ST_EDIT) && (r_idx == r_sel) && !r_phase;

    // ---- registered display outputs ----------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an      <= 4'b1111;
            r_seg_out <= BLANK;
        end else begin
            r_an      <= ~(4'b0001 << r_idx);
            r_seg_out <= w_blanked ? BLANK : w_seg_pick;
        end
    end

    assign num3      = r_digit[3];
    assign num2      = r_digit[2];
    assign num1      = r_digit[1];
    assign num0      = r_digit[0];
    assign sel       = r_sel;
    assign edit_mode = (r_state == ST_EDIT);
    assign an        = r_an;
    assign seg_out   = r_seg_out;

endmodule
